// File: rtl/ufm_page_rw_ctrl_pkg.sv
// Shared definitions for the UFM page transfer controller: FSM state
// encodings, UFM page geometry and the default first page.
package ufm_page_rw_ctrl_pkg;

  localparam int         UFM_PAGE_BYTES     = 16;
  localparam logic [7:0] DEFAULT_START_PAGE = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ERASE  = 3'd1,
    ST_WRITE  = 3'd2,
    ST_READ   = 3'd3,
    ST_VERIFY = 3'd4,
    ST_DONE   = 3'd5
  } ufm_state_e;

  // Number of 16-byte UFM pages needed to hold a word of the given size.
  function automatic int pages_for(input int bytes);
    return (bytes + UFM_PAGE_BYTES - 1) / UFM_PAGE_BYTES;
  endfunction

endpackage

// File: rtl/ufm_page_rw_ctrl_if.sv
// Command/data bus between the transfer controller (master) and the
// UFMRwPage WISHBONE page engine (slave).
interface ufm_page_rw_ctrl_if;

  logic       er_cmd;
  logic       wr_cmd;
  logic       rd_cmd;
  logic [7:0] page_addr;
  logic [7:0] page_num;
  logic [7:0] eng_wr_byte;
  logic [7:0] eng_wr_idx;
  logic [7:0] eng_rd_idx;
  logic [7:0] eng_rd_byte;
  logic       eng_rd_valid;
  logic       eng_erase_end;
  logic       eng_wr_end;
  logic       eng_rd_end;

  modport master (
    output er_cmd, wr_cmd, rd_cmd, page_addr, page_num, eng_wr_byte,
    input  eng_wr_idx, eng_rd_idx, eng_rd_byte, eng_rd_valid,
           eng_erase_end, eng_wr_end, eng_rd_end
  );

  modport slave (
    input  er_cmd, wr_cmd, rd_cmd, page_addr, page_num, eng_wr_byte,
    output eng_wr_idx, eng_rd_idx, eng_rd_byte, eng_rd_valid,
           eng_erase_end, eng_wr_end, eng_rd_end
  );

endinterface

// File: rtl/ufm_page_rw_ctrl_req_capture.sv
// ufm_req_capture: sticky flag set by a rising edge of an asynchronous
// request, cleared asynchronously by reset or by a one-cycle clear from the
// FSM, then brought into clk through two flops. The clear also flushes the
// synchroniser so an accepted request cannot be seen twice.
module ufm_req_capture (
  input  logic clk,
  input  logic wren_rstn,
  input  logic req_i,
  input  logic clr_i,
  output logic req_sync_o
);

  logic       flag_q;
  logic       flag_d;
  logic       flag_clr;
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // clr_i comes straight from a flop, so the OR cannot glitch on its own.
  assign flag_clr = ~wren_rstn | clr_i;

  // Flag next value: any request edge sets it.
  always_comb begin
    flag_d = 1'b1;
  end

  // Edge-set flag; an edge landing inside the clear window is lost.
  always_ff @(posedge req_i or posedge flag_clr) begin
    if (flag_clr) flag_q <= 1'b0;
    else          flag_q <= flag_d;
  end

  // Synchroniser next value, flushed together with the flag.
  always_comb begin
    sync_d = clr_i ? 2'b00 : {sync_q[0], flag_q};
  end

  // Two-flop synchroniser into clk.
  always_ff @(posedge clk or negedge wren_rstn) begin
    if (!wren_rstn) sync_q <= 2'b00;
    else            sync_q <= sync_d;
  end

  assign req_sync_o = sync_q[1];

endmodule

// File: rtl/ufm_page_rw_ctrl.sv
// Host-to-UFM transfer controller. Stores a DATA_BYTES word across
// consecutive 16-byte UFM pages starting at START_PAGE (erase, per-page
// program, optional read-back verify) and reads it back page by page.
// Build option: define UFM_VERIFY_EN to add the read-back verify pass and
// the verify_err port.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | waiting for a synced request; read wins over write
// ST_ERASE  | er_cmd high, waiting for eng_erase_end
// ST_WRITE  | wr_cmd high per page, shadow bytes served to the engine
// ST_READ   | rd_cmd high per page, bytes captured into rd_data
// ST_VERIFY | rd_cmd high per page, bytes compared against the shadow
// ST_DONE   | one cycle with done high, then back to idle
module ufm_page_rw_ctrl
  import ufm_page_rw_ctrl_pkg::*;
#(
  parameter int         DATA_BYTES = 4,
  parameter logic [7:0] START_PAGE = DEFAULT_START_PAGE
) (
  input  logic                    clk,
  input  logic                    wren_rstn,
  input  logic                    wr_req,
  input  logic                    rd_req,
  input  logic [8*DATA_BYTES-1:0] wr_data,
  output logic [8*DATA_BYTES-1:0] rd_data,
  output logic                    busy,
  output logic                    done,
`ifdef UFM_VERIFY_EN
  output logic                    verify_err,
`endif
  ufm_page_rw_ctrl_if.master      eng
);

  localparam int         PAGES  = pages_for(DATA_BYTES);
  localparam logic [7:0] LAST_P = 8'(PAGES - 1);

  if (DATA_BYTES < 1 || DATA_BYTES > 64) begin : g_bad_bytes
    $error("ufm_page_rw_ctrl: DATA_BYTES must be 1..64");
  end
  if (int'(START_PAGE) + PAGES > 256) begin : g_bad_pages
    $error("ufm_page_rw_ctrl: START_PAGE + PAGES exceeds 256");
  end

  ufm_state_e              state_q, state_d;
  logic                    er_cmd_q, er_cmd_d;
  logic                    wr_cmd_q, wr_cmd_d;
  logic                    rd_cmd_q, rd_cmd_d;
  logic [7:0]              page_addr_q, page_addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    clr_wr_q, clr_wr_d;
  logic                    clr_rd_q, clr_rd_d;
  logic [8*DATA_BYTES-1:0] rd_data_q, rd_data_d;
  logic [8*DATA_BYTES-1:0] shadow_q, shadow_d;
`ifdef UFM_VERIFY_EN
  logic                    verify_err_q, verify_err_d;
  logic [7:0]              exp_rd_byte;
`endif

  logic        wr_pend;
  logic        rd_pend;
  logic [7:0]  page_off;
  logic [15:0] wr_gidx;
  logic [15:0] rd_gidx;
  logic        rd_hit;
  logic [7:0]  wr_byte;

  ufm_req_capture u_wr_cap (
    .clk        (clk),
    .wren_rstn  (wren_rstn),
    .req_i      (wr_req),
    .clr_i      (clr_wr_q),
    .req_sync_o (wr_pend)
  );

  ufm_req_capture u_rd_cap (
    .clk        (clk),
    .wren_rstn  (wren_rstn),
    .req_i      (rd_req),
    .clr_i      (clr_rd_q),
    .req_sync_o (rd_pend)
  );

  // Global byte index of the engine's current write/read position.
  assign page_off = page_addr_q - START_PAGE;
  assign wr_gidx  = {4'd0, page_off, 4'd0} + {8'd0, eng.eng_wr_idx};
  assign rd_gidx  = {4'd0, page_off, 4'd0} + {8'd0, eng.eng_rd_idx};
  assign rd_hit   = eng.eng_rd_valid && (rd_gidx < 16'(DATA_BYTES));

  // Byte mux for the engine write path; past the word end the page is padded.
  always_comb begin
    wr_byte = 8'h00;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (wr_gidx == 16'(i)) wr_byte = shadow_q[8*i +: 8];
    end
  end

`ifdef UFM_VERIFY_EN
  // Shadow byte expected at the engine's current read position.
  always_comb begin
    exp_rd_byte = 8'h00;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (rd_gidx == 16'(i)) exp_rd_byte = shadow_q[8*i +: 8];
    end
  end
`endif

  // Next-state and output logic of the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    er_cmd_d    = er_cmd_q;
    wr_cmd_d    = wr_cmd_q;
    rd_cmd_d    = rd_cmd_q;
    page_addr_d = page_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    clr_wr_d    = 1'b0;
    clr_rd_d    = 1'b0;
    rd_data_d   = rd_data_q;
    shadow_d    = shadow_q;
`ifdef UFM_VERIFY_EN
    verify_err_d = verify_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rd_pend) begin
          clr_rd_d    = 1'b1;
          busy_d      = 1'b1;
          page_addr_d = START_PAGE;
          rd_cmd_d    = 1'b1;
          state_d     = ST_READ;
        end else if (wr_pend) begin
          clr_wr_d = 1'b1;
          shadow_d = wr_data;
          busy_d   = 1'b1;
          er_cmd_d = 1'b1;
`ifdef UFM_VERIFY_EN
          verify_err_d = 1'b0;
`endif
          state_d  = ST_ERASE;
        end
      end

      ST_ERASE: begin
        if (eng.eng_erase_end) begin
          er_cmd_d    = 1'b0;
          page_addr_d = START_PAGE;
          wr_cmd_d    = 1'b1;
          state_d     = ST_WRITE;
        end
      end

      ST_WRITE: begin
        // Holding wr_cmd high by default re-asserts it after the one-cycle gap.
        wr_cmd_d = 1'b1;
        if (eng.eng_wr_end && wr_cmd_q) begin
          wr_cmd_d = 1'b0;
          if (page_off == LAST_P) begin
`ifdef UFM_VERIFY_EN
            page_addr_d = START_PAGE;
            rd_cmd_d    = 1'b1;
            state_d     = ST_VERIFY;
`else
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
`endif
          end else begin
            page_addr_d = page_addr_q + 8'd1;
          end
        end
      end

      ST_READ: begin
        rd_cmd_d = 1'b1;
        if (rd_hit) begin
          for (int i = 0; i < DATA_BYTES; i++) begin
            if (rd_gidx == 16'(i)) rd_data_d[8*i +: 8] = eng.eng_rd_byte;
          end
        end
        if (eng.eng_rd_end && rd_cmd_q) begin
          rd_cmd_d = 1'b0;
          if (page_off == LAST_P) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            page_addr_d = page_addr_q + 8'd1;
          end
        end
      end

`ifdef UFM_VERIFY_EN
      ST_VERIFY: begin
        rd_cmd_d = 1'b1;
        if (rd_hit && (eng.eng_rd_byte != exp_rd_byte)) verify_err_d = 1'b1;
        if (eng.eng_rd_end && rd_cmd_q) begin
          rd_cmd_d = 1'b0;
          if (page_off == LAST_P) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            page_addr_d = page_addr_q + 8'd1;
          end
        end
      end
`endif

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops every command immediately.
  always_ff @(posedge clk or negedge wren_rstn) begin
    if (!wren_rstn) begin
      state_q     <= ST_IDLE;
      er_cmd_q    <= 1'b0;
      wr_cmd_q    <= 1'b0;
      rd_cmd_q    <= 1'b0;
      page_addr_q <= START_PAGE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      clr_wr_q    <= 1'b0;
      clr_rd_q    <= 1'b0;
      rd_data_q   <= '0;
      shadow_q    <= '0;
    end else begin
      state_q     <= state_d;
      er_cmd_q    <= er_cmd_d;
      wr_cmd_q    <= wr_cmd_d;
      rd_cmd_q    <= rd_cmd_d;
      page_addr_q <= page_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      clr_wr_q    <= clr_wr_d;
      clr_rd_q    <= clr_rd_d;
      rd_data_q   <= rd_data_d;
      shadow_q    <= shadow_d;
    end
  end

`ifdef UFM_VERIFY_EN
  // Sticky read-back mismatch flag, cleared when a new write is accepted.
  always_ff @(posedge clk or negedge wren_rstn) begin
    if (!wren_rstn) verify_err_q <= 1'b0;
    else            verify_err_q <= verify_err_d;
  end

  assign verify_err = verify_err_q;
`endif

  assign eng.er_cmd      = er_cmd_q;
  assign eng.wr_cmd      = wr_cmd_q;
  assign eng.rd_cmd      = rd_cmd_q;
  assign eng.page_addr   = page_addr_q;
  assign eng.page_num    = 8'h01;
  assign eng.eng_wr_byte = wr_byte;
  assign rd_data         = rd_data_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_ufm_page_rw_ctrl.sv
// Testbench for ufm_page_rw_ctrl: a 4-byte (one page) and a 20-byte
// (two page) instance share one behavioural page-engine model; sel picks
// which instance the model serves. Honours UFM_VERIFY_EN.
module tb_ufm_page_rw_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         wren_rstn;
  logic         wr_req_a, rd_req_a, wr_req_b, rd_req_b;
  logic [31:0]  wr_data_a, rd_data_a;
  logic [159:0] wr_data_b, rd_data_b;
  logic         busy_a, done_a, busy_b, done_b;
`ifdef UFM_VERIFY_EN
  logic         verr_a, verr_b;
`endif
  logic [7:0]   eng_wr_idx, eng_rd_idx, eng_rd_byte;
  logic         eng_rd_valid, eng_erase_end, eng_wr_end, eng_rd_end;

  ufm_page_rw_ctrl_if ifa ();
  ufm_page_rw_ctrl_if ifb ();

  assign ifa.eng_wr_idx    = eng_wr_idx;
  assign ifa.eng_rd_idx    = eng_rd_idx;
  assign ifa.eng_rd_byte   = eng_rd_byte;
  assign ifa.eng_rd_valid  = eng_rd_valid;
  assign ifa.eng_erase_end = eng_erase_end;
  assign ifa.eng_wr_end    = eng_wr_end;
  assign ifa.eng_rd_end    = eng_rd_end;
  assign ifb.eng_wr_idx    = eng_wr_idx;
  assign ifb.eng_rd_idx    = eng_rd_idx;
  assign ifb.eng_rd_byte   = eng_rd_byte;
  assign ifb.eng_rd_valid  = eng_rd_valid;
  assign ifb.eng_erase_end = eng_erase_end;
  assign ifb.eng_wr_end    = eng_wr_end;
  assign ifb.eng_rd_end    = eng_rd_end;

  ufm_page_rw_ctrl #(.DATA_BYTES(4), .START_PAGE(8'h01)) u_dut_a (
    .clk        (clk),
    .wren_rstn  (wren_rstn),
    .wr_req     (wr_req_a),
    .rd_req     (rd_req_a),
    .wr_data    (wr_data_a),
    .rd_data    (rd_data_a),
    .busy       (busy_a),
    .done       (done_a),
`ifdef UFM_VERIFY_EN
    .verify_err (verr_a),
`endif
    .eng        (ifa)
  );

  ufm_page_rw_ctrl #(.DATA_BYTES(20), .START_PAGE(8'h01)) u_dut_b (
    .clk        (clk),
    .wren_rstn  (wren_rstn),
    .wr_req     (wr_req_b),
    .rd_req     (rd_req_b),
    .wr_data    (wr_data_b),
    .rd_data    (rd_data_b),
    .busy       (busy_b),
    .done       (done_b),
`ifdef UFM_VERIFY_EN
    .verify_err (verr_b),
`endif
    .eng        (ifb)
  );

  bit         sel;
  wire        e_er      = sel ? ifb.er_cmd      : ifa.er_cmd;
  wire        e_wr      = sel ? ifb.wr_cmd      : ifa.wr_cmd;
  wire        e_rd      = sel ? ifb.rd_cmd      : ifa.rd_cmd;
  wire [7:0]  e_page    = sel ? ifb.page_addr   : ifa.page_addr;
  wire [7:0]  e_wr_byte = sel ? ifb.eng_wr_byte : ifa.eng_wr_byte;
  wire        e_done    = sel ? done_b          : done_a;
  wire        e_busy    = sel ? busy_b          : busy_a;

  int         errors = 0;
  int         checks = 0;
  int         done_cnt, erase_cnt, gap_delta;
  bit         gap_bad, to;
  byte        first_cmd;
  int         wr_pages[$];
  int         rd_pages[$];
  logic [7:0] mem [2][256][16];

  task automatic tick(inout int cyc);
    @(negedge clk);
    cyc++;
    if (e_done) done_cnt++;
  endtask

  // Behavioural page engine: serves erase/write/read commands until n_done
  // done pulses have been seen or the cycle budget runs out.
  task automatic serve(input int n_done, input bit corrupt, output bit tmo);
    int cyc = 0;
    int pg;
    int last_end = -100;
    done_cnt  = 0;
    erase_cnt = 0;
    gap_delta = -1;
    gap_bad   = 1'b0;
    first_cmd = 8'd0;
    wr_pages.delete();
    rd_pages.delete();
    tmo = 1'b0;
    while (done_cnt < n_done) begin
      if (cyc > 2000) begin
        tmo = 1'b1;
        break;
      end
      if (e_er) begin
        if (first_cmd == 8'd0) first_cmd = "E";
        repeat (4) tick(cyc);
        eng_erase_end = 1'b1;
        tick(cyc);
        eng_erase_end = 1'b0;
        erase_cnt++;
      end else if (e_wr) begin
        pg = int'(e_page);
        wr_pages.push_back(pg);
        if (wr_pages.size() > 1) gap_delta = cyc - last_end;
        for (int i = 0; i < 16; i++) begin
          eng_wr_idx = 8'(i);
          #1;
          mem[sel][pg][i] = e_wr_byte;
          tick(cyc);
        end
        eng_wr_end = 1'b1;
        tick(cyc);
        eng_wr_end = 1'b0;
        last_end = cyc;
        if (e_wr) gap_bad = 1'b1;
      end else if (e_rd) begin
        if (first_cmd == 8'd0) first_cmd = "R";
        pg = int'(e_page);
        rd_pages.push_back(pg);
        for (int i = 0; i < 16; i++) begin
          eng_rd_idx   = 8'(i);
          eng_rd_byte  = mem[sel][pg][i] ^ ((corrupt && i == 2) ? 8'hFF : 8'h00);
          eng_rd_valid = 1'b1;
          tick(cyc);
        end
        eng_rd_valid = 1'b0;
        eng_rd_end   = 1'b1;
        tick(cyc);
        eng_rd_end   = 1'b0;
      end else begin
        tick(cyc);
      end
    end
  endtask

  task automatic test_reset();
    int c = 0;
    wren_rstn = 1'b0;
    {wr_req_a, rd_req_a, wr_req_b, rd_req_b} = 4'b0;
    wr_data_a = '0;
    wr_data_b = '0;
    {eng_wr_idx, eng_rd_idx, eng_rd_byte} = '0;
    {eng_rd_valid, eng_erase_end, eng_wr_end, eng_rd_end} = 4'b0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy_a, done_a, busy_b, done_b} !== 4'b0) begin
      errors++; $display("FAIL reset_status: busy/done a,b=%b expected 0000", {busy_a, done_a, busy_b, done_b}); end
    checks++; if ({ifa.er_cmd, ifa.wr_cmd, ifa.rd_cmd, ifb.er_cmd, ifb.wr_cmd, ifb.rd_cmd} !== 6'b0) begin
      errors++; $display("FAIL reset_cmds: got %b expected 000000", {ifa.er_cmd, ifa.wr_cmd, ifa.rd_cmd, ifb.er_cmd, ifb.wr_cmd, ifb.rd_cmd}); end
    checks++; if (ifa.page_addr !== 8'h01 || ifb.page_addr !== 8'h01) begin
      errors++; $display("FAIL reset_page_addr: a=%h b=%h expected 01", ifa.page_addr, ifb.page_addr); end
    checks++; if (rd_data_a !== 32'h0 || rd_data_b !== 160'h0) begin
      errors++; $display("FAIL reset_rd_data: a=%h b=%h expected 0", rd_data_a, rd_data_b); end
    checks++; if (ifa.page_num !== 8'h01) begin
      errors++; $display("FAIL page_num: got %h expected 01", ifa.page_num); end
`ifdef UFM_VERIFY_EN
    checks++; if ({verr_a, verr_b} !== 2'b00) begin
      errors++; $display("FAIL reset_verify_err: got %b expected 00", {verr_a, verr_b}); end
`endif
    wren_rstn = 1'b1;
    repeat (4) tick(c);
    checks++; if ({ifa.er_cmd, ifa.rd_cmd, busy_a} !== 3'b0) begin
      errors++; $display("FAIL idle_after_reset: er/rd/busy=%b expected 000", {ifa.er_cmd, ifa.rd_cmd, busy_a}); end
  endtask

  task automatic test_write_single();
    logic [7:0] exp_b [4] = '{8'h11, 8'h0F, 8'hC3, 8'hA5};
    logic [7:0] exp;
    int c = 0;
    sel = 1'b0;
    wr_data_a = 32'hA5C3_0F11;
    @(negedge clk); wr_req_a = 1'b1;
    serve(1, 1'b0, to);
    wr_req_a = 1'b0;
    repeat (5) tick(c);
    checks++; if (to) begin errors++; $display("FAIL wr1_timeout: done count %0d required 1", done_cnt); end
    checks++; if (erase_cnt !== 1) begin errors++; $display("FAIL wr1_erase_cnt: got %0d expected 1", erase_cnt); end
    checks++; if (wr_pages.size() != 1 || wr_pages[0] != 1) begin
      errors++; $display("FAIL wr1_pages: got %0d pages first %0d expected 1 page at 1", wr_pages.size(), wr_pages[0]); end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 4) ? exp_b[i] : 8'h00;
      checks++; if (mem[0][1][i] !== exp) begin
        errors++; $display("FAIL wr1_byte[%0d]: got %h expected %h", i, mem[0][1][i], exp); end
    end
    checks++; if (done_cnt !== 1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL wr1_done_busy: done pulses %0d busy %b expected 1 and 0", done_cnt, busy_a); end
  endtask

  task automatic test_read_single();
    int c = 0;
    sel = 1'b0;
    @(negedge clk); rd_req_a = 1'b1;
    serve(1, 1'b0, to);
    rd_req_a = 1'b0;
    repeat (3) tick(c);
    checks++; if (to) begin errors++; $display("FAIL rd1_timeout: done count %0d required 1", done_cnt); end
    checks++; if (rd_data_a !== 32'hA5C3_0F11) begin
      errors++; $display("FAIL rd1_data: got %h expected a5c30f11", rd_data_a); end
    checks++; if (rd_pages.size() != 1 || rd_pages[0] != 1 || wr_pages.size() != 0 || erase_cnt != 0) begin
      errors++; $display("FAIL rd1_pages: rd pages %0d first %0d wr pages %0d erases %0d expected 1,1,0,0",
                         rd_pages.size(), rd_pages[0], wr_pages.size(), erase_cnt); end
    checks++; if (done_cnt !== 1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL rd1_done_busy: done pulses %0d busy %b expected 1 and 0", done_cnt, busy_a); end
  endtask

  task automatic test_write_multi();
    logic [7:0] exp;
    int c = 0;
    sel = 1'b1;
    for (int i = 0; i < 20; i++) wr_data_b[8*i +: 8] = 8'h30 + 8'(i);
    @(negedge clk); wr_req_b = 1'b1;
    serve(1, 1'b0, to);
    wr_req_b = 1'b0;
    repeat (3) tick(c);
    checks++; if (to) begin errors++; $display("FAIL wr2_timeout: done count %0d required 1", done_cnt); end
    checks++; if (erase_cnt !== 1) begin errors++; $display("FAIL wr2_erase_cnt: got %0d expected 1", erase_cnt); end
    checks++; if (wr_pages.size() != 2 || wr_pages[0] != 1 || wr_pages[1] != 2) begin
      errors++; $display("FAIL wr2_pages: got %0d pages (%0d,%0d) expected 2 pages (1,2)", wr_pages.size(), wr_pages[0], wr_pages[1]); end
    checks++; if (gap_bad || gap_delta != 1) begin
      errors++; $display("FAIL wr2_gap: gap_bad %b gap %0d cycles expected 0 and 1", gap_bad, gap_delta); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (mem[1][1][i] !== 8'h30 + 8'(i)) begin
        errors++; $display("FAIL wr2_p1_byte[%0d]: got %h expected %h", i, mem[1][1][i], 8'h30 + 8'(i)); end
      exp = (i < 4) ? 8'h40 + 8'(i) : 8'h00;
      checks++; if (mem[1][2][i] !== exp) begin
        errors++; $display("FAIL wr2_p2_byte[%0d]: got %h expected %h", i, mem[1][2][i], exp); end
    end
    checks++; if (done_cnt !== 1 || busy_b !== 1'b0) begin
      errors++; $display("FAIL wr2_done_busy: done pulses %0d busy %b expected 1 and 0", done_cnt, busy_b); end
  endtask

  task automatic test_read_multi();
    logic [159:0] exp;
    int c = 0;
    for (int i = 0; i < 20; i++) exp[8*i +: 8] = 8'h30 + 8'(i);
    sel = 1'b1;
    @(negedge clk); rd_req_b = 1'b1;
    serve(1, 1'b0, to);
    rd_req_b = 1'b0;
    repeat (3) tick(c);
    checks++; if (to) begin errors++; $display("FAIL rd2_timeout: done count %0d required 1", done_cnt); end
    checks++; if (rd_data_b !== exp) begin
      errors++; $display("FAIL rd2_data: got %h expected %h", rd_data_b, exp); end
    checks++; if (rd_pages.size() != 2 || rd_pages[0] != 1 || rd_pages[1] != 2) begin
      errors++; $display("FAIL rd2_pages: got %0d pages (%0d,%0d) expected (1,2)", rd_pages.size(), rd_pages[0], rd_pages[1]); end
  endtask

  task automatic test_back_to_back();
    int c = 0;
    sel = 1'b0;
    wr_data_a = 32'h1234_5678;
    @(negedge clk); wr_req_a = 1'b1; rd_req_a = 1'b1;
    serve(2, 1'b0, to);
    wr_req_a = 1'b0; rd_req_a = 1'b0;
    repeat (5) tick(c);
    checks++; if (to) begin errors++; $display("FAIL b2b_timeout: done count %0d required 2", done_cnt); end
    checks++; if (first_cmd !== "R") begin errors++; $display("FAIL b2b_order: first command %c expected R", first_cmd); end
    checks++; if (done_cnt !== 2 || erase_cnt !== 1) begin
      errors++; $display("FAIL b2b_counts: done %0d erases %0d expected 2 and 1", done_cnt, erase_cnt); end
    checks++; if (rd_data_a !== 32'hA5C3_0F11) begin
      errors++; $display("FAIL b2b_old_data: got %h expected a5c30f11", rd_data_a); end
    checks++; if ({mem[0][1][3], mem[0][1][2], mem[0][1][1], mem[0][1][0]} !== 32'h1234_5678) begin
      errors++; $display("FAIL b2b_written: got %h expected 12345678", {mem[0][1][3], mem[0][1][2], mem[0][1][1], mem[0][1][0]}); end
    @(negedge clk); rd_req_a = 1'b1;
    serve(1, 1'b0, to);
    rd_req_a = 1'b0;
    checks++; if (to || rd_data_a !== 32'h1234_5678) begin
      errors++; $display("FAIL b2b_new_data: got %h (timeout %b) expected 12345678", rd_data_a, to); end
  endtask

`ifdef UFM_VERIFY_EN
  task automatic test_verify();
    int c = 0;
    sel = 1'b0;
    wr_data_a = 32'hDEAD_BEEF;
    @(negedge clk); wr_req_a = 1'b1;
    serve(1, 1'b1, to);
    wr_req_a = 1'b0;
    repeat (3) tick(c);
    checks++; if (to || verr_a !== 1'b1) begin
      errors++; $display("FAIL verify_err_set: got %b (timeout %b) expected 1", verr_a, to); end
    checks++; if (rd_data_a !== 32'h1234_5678) begin
      errors++; $display("FAIL verify_rd_data: got %h expected 12345678", rd_data_a); end
    wr_data_a = 32'h0BAD_F00D;
    @(negedge clk); wr_req_a = 1'b1;
    serve(1, 1'b0, to);
    wr_req_a = 1'b0;
    repeat (3) tick(c);
    checks++; if (to || verr_a !== 1'b0) begin
      errors++; $display("FAIL verify_err_clear: got %b (timeout %b) expected 0", verr_a, to); end
  endtask
`endif

  task automatic test_abort();
    int c = 0;
    int lat = 0;
    bit any_cmd = 1'b0;
    sel = 1'b0;
    @(negedge clk); wr_req_a = 1'b1;
    while (!e_er && lat < 20) begin
      tick(c);
      lat++;
    end
    checks++; if (lat != 3) begin errors++; $display("FAIL req_latency: er_cmd after %0d clk expected 3", lat); end
    @(negedge clk); rd_req_a = 1'b1;
    repeat (3) @(negedge clk);
    wren_rstn = 1'b0;
    #1;
    checks++; if ({ifa.er_cmd, ifa.wr_cmd, ifa.rd_cmd} !== 3'b000) begin
      errors++; $display("FAIL abort_cmds: got %b expected 000", {ifa.er_cmd, ifa.wr_cmd, ifa.rd_cmd}); end
    checks++; if ({busy_a, done_a} !== 2'b00 || ifa.page_addr !== 8'h01 || rd_data_a !== 32'h0) begin
      errors++; $display("FAIL abort_outputs: busy %b done %b page %h rd_data %h expected 0 0 01 0",
                         busy_a, done_a, ifa.page_addr, rd_data_a); end
    @(negedge clk); wren_rstn = 1'b1;
    wr_req_a = 1'b0; rd_req_a = 1'b0;
    done_cnt = 0;
    repeat (20) begin
      tick(c);
      if (e_er || e_wr || e_rd) any_cmd = 1'b1;
    end
    checks++; if (done_cnt !== 0 || any_cmd !== 1'b0) begin
      errors++; $display("FAIL abort_quiet: done pulses %0d commands seen %b expected 0 and 0", done_cnt, any_cmd); end
  endtask

  initial begin
    test_reset();
    test_write_single();
    test_read_single();
    test_write_multi();
    test_read_multi();
    test_back_to_back();
`ifdef UFM_VERIFY_EN
    test_verify();
`endif
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ufm_page_rw_ctrl.md
# ufm_page_rw_ctrl

Parametrised host-to-UFM transfer controller for the MXO2 user flash memory. It sits between the LPC-side register decode and the UFMRwPage WISHBONE page engine. It accepts asynchronous write and read requests and stores a DATA_BYTES-wide word across as many consecutive 16-byte UFM pages as the word needs. The sequence is erase, per-page program, then optional read-back verify. Reads run per page and return the word on a parallel bus with busy and done status.

## Interface
- DATA_BYTES, 4: stored word size in bytes, 1..64; PAGES = ceil(DATA_BYTES/16) (localparam)
- START_PAGE, 8'h01: first UFM page used
- clk  in  1  internal oscillator clock, same as engine/WISHBONE clock
- wren_rstn  in  1  reset, asynchronous, active-low
- wr_req  in  1  asynchronous; rising edge requests a write
- rd_req  in  1  asynchronous; rising edge requests a read
- wr_data  in  8*DATA_BYTES  word to store; byte 0 = [7:0]
- rd_data  out  8*DATA_BYTES  last word read
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at the end of each transfer
- verify_err  out  1  read-back mismatch (present only with UFM_VERIFY_EN)
- er_cmd / wr_cmd / rd_cmd  out  1 each  engine commands
- page_addr  out  8  engine page start address
- page_num  out  8  engine page count; constant 8'h01
- eng_wr_byte  out  8  byte selected by eng_wr_idx
- eng_wr_idx / eng_rd_idx  in  8 each  engine byte index within the page, 0..15
- eng_rd_byte  in  8  engine read byte
- eng_rd_valid  in  1  engine read cycle active (byte valid)
- eng_erase_end / eng_wr_end / eng_rd_end  in  1 each  engine end strobes

## Operation
- Request capture: each request has an edge-set sticky flag, asynchronously cleared by wren_rstn or by a one-cycle clear from the FSM. The flag is 2-flop synchronised into clk.
- An edge that arrives during its own clear cycle is lost. An edge that arrives while busy sets the flag and is serviced after the FSM returns to IDLE.
- States: IDLE, ERASE, WRITE, READ, VERIFY (macro only), DONE.
- IDLE, synced read flag set: clear it, set busy, page_addr=START_PAGE, go to READ. Read has priority when both flags are set.
- IDLE, synced write flag set: clear it, latch wr_data into a shadow register, set busy, assert er_cmd, go to ERASE. Acceptance also clears verify_err.
- ERASE: on eng_erase_end, drop er_cmd, page_addr=START_PAGE, assert wr_cmd, go to WRITE.
- WRITE: eng_wr_byte = shadow byte at p*16+eng_wr_idx, where p = page_addr-START_PAGE. Indices at or beyond DATA_BYTES give 8'h00 (padding).
- WRITE, on eng_wr_end: drop wr_cmd for exactly one cycle. If pages remain, increment page_addr and re-assert wr_cmd. On the last page, go to VERIFY (macro) or DONE.
- READ / VERIFY: rd_cmd stays asserted per page. Each clk with eng_rd_valid and global index < DATA_BYTES acts on that byte:
  - READ stores it into rd_data.
  - VERIFY compares it with the shadow and sets verify_err on mismatch; rd_data is untouched.
- READ / VERIFY, on eng_rd_end: page advance works the same way as in WRITE. After the last page go to DONE.
- DONE: pulse done, clear busy, then IDLE.
- Arithmetic: page_addr wraps modulo 256. START_PAGE+PAGES must not exceed 256 (parameter check).

## Timing
- All state on posedge clk.
- Reset values: busy 0, done 0, verify_err 0, all cmds 0, page_addr START_PAGE, rd_data 0, shadow 0, FSM IDLE.
- Request latency: 2 clk synchroniser, then 1 clk to a command asserted.
- rd_data bytes update 1 clk after the eng_rd_valid sample.
- done follows the last end strobe by 1 clk, and busy falls in the same cycle as done.
- wren_rstn low mid-operation aborts immediately: commands drop asynchronously and pending flags clear. The UFM content is then undefined.
- The erase takes 500–900 ms; there is no internal timeout.

## Configuration
- UFM_VERIFY_EN defined: a VERIFY pass follows every write, and the verify_err port exists.
- UFM_VERIFY_EN undefined: WRITE goes straight to DONE, the port and the compare logic are absent, and write transfers are shorter by the read time.

## Structure
- Shared package (DefineEFBTextMacro-style include) holds:
  - state encodings;
  - UFM_PAGE_BYTES=16;
  - the default START_PAGE.
- One sub-module, ufm_req_capture: edge-set/async-clear flag plus 2-flop sync, instantiated for wr_req and rd_req.

## Test plan
- DATA_BYTES=4, wr_data=32'hA5C3_0F11, write:
  - one erase, then one page written with bytes 11,0F,C3,A5, and 0 for idx 4–15;
  - done pulses once, busy is low afterwards.
- Read after that write: rd_data=32'hA5C3_0F11 with rd_cmd on page START_PAGE only.
- DATA_BYTES=20: the write issues pages 1 and 2, with a one-cycle wr_cmd gap between them. Page 2 idx 4–15 = 0. A read returns all 20 bytes.
- rd_req and wr_req edges in the same cycle: read runs first, then the write without a new edge, giving two done pulses.
- UFM_VERIFY_EN with the engine model corrupting byte 2: verify_err=1 and rd_data unchanged. The next clean write clears verify_err.
- wren_rstn asserted during ERASE: all outputs return to reset values within the same cycle, and no done pulse occurs.
